t_bird_seq_ctrl: RTL

//  Parametrised successor of the fixed 3-lamp turn-signal FSM. Drives LAMPS lamps per side as
//  a thermometer sweep (left/right) or an all-lamp flash (hazard), one step per prescaled tick.

---
 rtl/t_bird_seq_ctrl.sv | 85 ++++++++
 1 files changed

// File: rtl/t_bird_seq_ctrl.sv
// t_bird_seq_ctrl: parametrised turn-signal/hazard lamp sequencer with prescaled stepping
module t_bird_seq_ctrl #(
   parameter int LAMPS    = 3,
   parameter int TICK_DIV = 4,
   localparam int SW      = $clog2(LAMPS + 1)
) (
   input  logic             clk,
   input  logic             clr_n,
   input  logic             left,
   input  logic             right,
   input  logic             haz,
   output logic [LAMPS-1:0] l_lamps,
   output logic [LAMPS-1:0] r_lamps,
   output logic [1:0]       mode,
   output logic [SW-1:0]    step,
   output logic             tick
);
   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [1:0] M_OFF = 2'b00, M_LEFT = 2'b01, M_RIGHT = 2'b10, M_HAZ = 2'b11;

   logic [CW-1:0]  div_cnt;
   logic [1:0]     nxt_mode, idle_mode;
   logic [SW-1:0]  nxt_step, idle_step;
   logic           hreq;
   logic [LAMPS:0] one_hot;
   logic [LAMPS-1:0] therm;

   assign tick = (div_cnt == CW'(TICK_DIV - 1));
   assign hreq = haz | (left & right);

   // prescaler: counts 0..TICK_DIV-1 and wraps on tick
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) div_cnt <= '0;
      else        div_cnt <= tick ? '0 : div_cnt + CW'(1);
   end

   // state register: {mode, step} advances only on tick edges
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         mode <= M_OFF;
         step <= '0;
      end else if (tick) begin
         mode <= nxt_mode;
         step <= nxt_step;
      end
   end

   // next state: idle decision shared by OFF and the hazard off phase; illegal codes fall to OFF/0
   always_comb begin
      idle_mode = hreq ? M_HAZ : left ? M_LEFT : right ? M_RIGHT : M_OFF;
      idle_step = (hreq | left | right) ? SW'(1) : '0;
      nxt_mode  = M_OFF;
      nxt_step  = '0;
      case (mode)
         M_OFF: begin
            if (step == '0) begin
               nxt_mode = idle_mode;
               nxt_step = idle_step;
            end
         end
         M_LEFT, M_RIGHT: begin
            if (step < SW'(LAMPS)) begin
               nxt_mode = hreq ? M_HAZ : mode;
               nxt_step = hreq ? SW'(1) : step + SW'(1);
            end
         end
         default: begin
            if (step == SW'(1)) begin
               nxt_mode = M_HAZ;
            end else if (step == '0) begin
               nxt_mode = idle_mode;
               nxt_step = idle_step;
            end
         end
      endcase
   end

   // lamp decode from registered state only; thermometer built one bit wider to avoid overflow
   always_comb begin
      one_hot = (LAMPS + 1)'(1) << step;
      therm   = LAMPS'(one_hot - (LAMPS + 1)'(1));
      l_lamps = (mode == M_LEFT)  ? therm : (mode == M_HAZ && step == SW'(1)) ? '1 : '0;
      r_lamps = (mode == M_RIGHT) ? therm : (mode == M_HAZ && step == SW'(1)) ? '1 : '0;
   end
endmodule
